// File: rtl/time_counter.sv
// -----------------------------------------------------------------------------
// time_counter
//
// Free-running HH:MM:SS timekeeper. A prescaler divides the system clock down
// to a one-second tick, and the tick advances a seconds -> minutes -> hours
// cascade with a 24 hour wrap. An edited time can be loaded in parallel; the
// load has priority over counting and restarts the one-second period.
//
// Ports
//   clk_100MHz_i    in   1  system clock, rising edge
//   reset_n_i       in   1  asynchronous active-low reset
//   count_enable_i  in   1  1 = time advances, 0 = time frozen (edit mode)
//   load_time_i     in   1  level; while high the time registers take load_*
//   load_seconds_i  in   6  seconds to load (values above 59 saturate to 59)
//   load_minutes_i  in   6  minutes to load (values above 59 saturate to 59)
//   load_hours_i    in   5  hours to load   (values above 23 saturate to 23)
//   seconds_o       out  6  current seconds 0..59
//   minutes_o       out  6  current minutes 0..59
//   hours_o         out  5  current hours   0..23
//   tick_1hz_o      out  1  one-cycle pulse on the cycle seconds_o advances
//   day_wrap_o      out  1  one-cycle pulse on the 23:59:59 -> 00:00:00 step
//
// Handshake: there is no valid/ready pairing here. load_time_i is a level
// qualifier sampled on every rising edge; count_enable_i is a level gate.
// The upstream edit FSM loads with enable low, then raises enable a cycle
// later, which gives a full one-second first period after the load.
// -----------------------------------------------------------------------------
module time_counter #(
  parameter int CLK_FREQ_HZ = 100_000_000
) (
  input  logic       clk_100MHz_i,
  input  logic       reset_n_i,
  input  logic       count_enable_i,
  input  logic       load_time_i,
  input  logic [5:0] load_seconds_i,
  input  logic [5:0] load_minutes_i,
  input  logic [4:0] load_hours_i,
  output logic [5:0] seconds_o,
  output logic [5:0] minutes_o,
  output logic [4:0] hours_o,
  output logic       tick_1hz_o,
  output logic       day_wrap_o
);

  localparam int PW = $clog2(CLK_FREQ_HZ);
  localparam logic [PW-1:0] PRESC_TERM = PW'(CLK_FREQ_HZ - 1);

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q,   sec_d;
  logic [5:0]    min_q,   min_d;
  logic [4:0]    hour_q,  hour_d;
  logic          tick_q,  tick_d;
  logic          wrap_q,  wrap_d;

  // ---------------------------------------------------------------------------
  // Load saturation: out-of-range edits clamp to the top legal value rather
  // than wrapping, so a bad edit never produces an illegal displayed time.
  // ---------------------------------------------------------------------------
  logic [5:0] load_sec_sat;
  logic [5:0] load_min_sat;
  logic [4:0] load_hour_sat;

  always_comb begin
    load_sec_sat  = (load_seconds_i > SEC_MAX)  ? SEC_MAX  : load_seconds_i;
    load_min_sat  = (load_minutes_i > MIN_MAX)  ? MIN_MAX  : load_minutes_i;
    load_hour_sat = (load_hours_i   > HOUR_MAX) ? HOUR_MAX : load_hours_i;
  end

  // ---------------------------------------------------------------------------
  // Carry terms. All three fields update on the same edge as the tick, so
  // the carries are plain combinational terms off the current register values.
  // ---------------------------------------------------------------------------
  logic presc_at_term;
  logic sec_at_max;
  logic min_at_max;
  logic hour_at_max;

  always_comb begin
    presc_at_term = (presc_q == PRESC_TERM);
    sec_at_max    = (sec_q   == SEC_MAX);
    min_at_max    = (min_q   == MIN_MAX);
    hour_at_max   = (hour_q  == HOUR_MAX);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Priority: load, then enable gate, then counting.
  // ---------------------------------------------------------------------------
  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;

    if (load_time_i) begin
      // Load also clears the prescaler and suppresses any coincident tick.
      presc_d = '0;
      sec_d   = load_sec_sat;
      min_d   = load_min_sat;
      hour_d  = load_hour_sat;
    end else if (!count_enable_i) begin
      // Holding the prescaler at zero makes the first advance after
      // re-enable land exactly one full period later.
      presc_d = '0;
    end else if (presc_at_term) begin
      presc_d = '0;
      tick_d  = 1'b1;
      if (!sec_at_max) begin
        sec_d = sec_q + 6'd1;
      end else begin
        sec_d = '0;
        if (!min_at_max) begin
          min_d = min_q + 6'd1;
        end else begin
          min_d = '0;
          if (!hour_at_max) begin
            hour_d = hour_q + 5'd1;
          end else begin
            hour_d = '0;
            wrap_d = 1'b1;
          end
        end
      end
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_100MHz_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: straight from registers, so held values never glitch.
  // ---------------------------------------------------------------------------
  assign seconds_o  = sec_q;
  assign minutes_o  = min_q;
  assign hours_o    = hour_q;
  assign tick_1hz_o = tick_q;
  assign day_wrap_o = wrap_q;

endmodule
